// File: rtl/vga_rect_engine_if.sv
// rtl/vga_rect_engine_if.sv - rectangle config write handshake for vga_rect_engine
interface vga_rect_engine_if #(
  parameter int IW = 1,
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int CW = 9
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [IW-1:0] cfg_idx;
  logic [HW-1:0] cfg_w;
  logic [VW-1:0] cfg_h;
  logic [CW-1:0] cfg_color;

  modport master (output cfg_valid, cfg_idx, cfg_w, cfg_h, cfg_color, input cfg_ready);
  modport slave  (input cfg_valid, cfg_idx, cfg_w, cfg_h, cfg_color, output cfg_ready);
endinterface

// File: rtl/vga_rect_engine.sv
// rtl/vga_rect_engine.sv - VGA raster timing plus N_RECT centred, prioritised, flashing rectangles
module vga_rect_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int CLK_DIV      = 2,
  parameter int CDEPTH       = 3,
  parameter int N_RECT       = 2,
  parameter int FLASH_FRAMES = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  vga_rect_engine_if.slave  cfg,
  input  logic              i_rev,
  input  logic              i_flash_en,
  output logic              o_h_sync,
  output logic              o_v_sync,
  output logic [CDEPTH-1:0] o_red,
  output logic [CDEPTH-1:0] o_green,
  output logic [CDEPTH-1:0] o_blue,
  output logic              o_frame_start
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int IW = (N_RECT > 1) ? $clog2(N_RECT) : 1;
  localparam int CW = 3 * CDEPTH;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic [HW-1:0] r_rw [N_RECT];
  logic [VW-1:0] r_rh [N_RECT];
  logic [CW-1:0] r_rc [N_RECT];
  logic          r_pend;
  logic [IW-1:0] r_pidx;
  logic [HW-1:0] r_pw;
  logic [VW-1:0] r_ph;
  logic [CW-1:0] r_pc;

  logic              w_pe, w_hend, w_vend, w_fstart, w_commit, w_accept;
  logic              w_active, w_hit, w_show;
  logic [N_RECT-1:0] w_in;
  logic [CW-1:0]     w_color, w_rgb;

  assign w_pe          = (r_div == DW'(CLK_DIV - 1));
  assign w_hend        = (r_hcnt == HW'(HT - 1));
  assign w_vend        = (r_vcnt == VW'(VT - 1));
  assign w_fstart      = w_pe && (r_hcnt == '0) && (r_vcnt == '0);
  assign w_commit      = w_pe && w_hend && w_vend && r_pend;
  assign w_accept      = cfg.cfg_valid && !r_pend;
  assign cfg.cfg_ready = !r_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      r_div <= w_pe ? '0 : r_div + 1'b1;
      if (w_pe) begin
        r_hcnt <= w_hend ? '0 : r_hcnt + 1'b1;
        if (w_hend) r_vcnt <= w_vend ? '0 : r_vcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_fstart) begin
      if (r_fcnt == FW'(FLASH_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  // Writes park in one slot and land only at the last pixel of a frame,
  // so every frame is drawn from a consistent rectangle set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
      r_pidx <= '0;
      r_pw   <= '0;
      r_ph   <= '0;
      r_pc   <= '0;
      for (int i = 0; i < N_RECT; i++) begin
        r_rw[i] <= '0;
        r_rh[i] <= '0;
        r_rc[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_pend <= 1'b1;
        r_pidx <= cfg.cfg_idx;
        r_pw   <= cfg.cfg_w;
        r_ph   <= cfg.cfg_h;
        r_pc   <= cfg.cfg_color;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
      if (w_commit) begin
        for (int i = 0; i < N_RECT; i++) begin
          if (r_pidx == IW'(i)) begin
            r_rw[i] <= r_pw;
            r_rh[i] <= r_ph;
            r_rc[i] <= r_pc;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < N_RECT; g++) begin : g_rect
    logic [HW-1:0] w_wc, w_xlo;
    logic [VW-1:0] w_hc, w_ylo;
    assign w_wc    = (r_rw[g] > HW'(H_ACTIVE)) ? HW'(H_ACTIVE) : r_rw[g];
    assign w_hc    = (r_rh[g] > VW'(V_ACTIVE)) ? VW'(V_ACTIVE) : r_rh[g];
    assign w_xlo   = (HW'(H_ACTIVE) - w_wc) >> 1;
    assign w_ylo   = (VW'(V_ACTIVE) - w_hc) >> 1;
    assign w_in[g] = (r_hcnt >= w_xlo) && (r_hcnt < w_xlo + w_wc) &&
                     (r_vcnt >= w_ylo) && (r_vcnt < w_ylo + w_hc);
  end

  // Scan from the highest index down so the lowest-index hit is the one kept.
  always_comb begin
    w_hit   = 1'b0;
    w_color = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        w_hit   = 1'b1;
        w_color = r_rc[i];
      end
    end
  end

  assign w_active = (r_hcnt < HW'(H_ACTIVE)) && (r_vcnt < VW'(V_ACTIVE));
  assign w_show   = w_hit && !(i_flash_en && r_phase);

  always_comb begin
    w_rgb = '0;
    if (w_active) begin
      if (i_rev) w_rgb = w_show ? ~w_color : '1;
      else       w_rgb = w_show ? w_color : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_h_sync      <= 1'b1;
      o_v_sync      <= 1'b1;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= w_fstart;
      if (w_pe) begin
        o_h_sync <= !((r_hcnt >= HW'(H_ACTIVE + H_FP)) && (r_hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
        o_v_sync <= !((r_vcnt >= VW'(V_ACTIVE + V_FP)) && (r_vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
        {o_red, o_green, o_blue} <= w_rgb;
      end
    end
  end
endmodule
